mvm_feeder: RTL

//  Upstream/downstream sequencer for the k-by-k matrix-vector multiplier. Accepts matrix/vector frames on a

---
 rtl/mvm_pkg.sv | 25 ++
 rtl/mvm_feeder_if.sv | 18 +
 rtl/mvm_frame_buf.sv | 23 ++
 rtl/mvm_feeder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// Shared state encodings and frame-size helpers for the matrix-vector multiplier feeder.
package mvm_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_COLLECT = 4'd0;
    localparam state_t ST_LDM     = 4'd1;
    localparam state_t ST_SENDM   = 4'd2;
    localparam state_t ST_LDV     = 4'd3;
    localparam state_t ST_SENDV   = 4'd4;
    localparam state_t ST_STRT    = 4'd5;
    localparam state_t ST_WAIT    = 4'd6;
    localparam state_t ST_CAPT    = 4'd7;
    localparam state_t ST_DRAIN   = 4'd8;

    // Matrix frames carry K*K row-major elements followed by the K-element vector.
    function automatic int mat_frame_words(input int k);
        return k * k + k;
    endfunction

    function automatic int vec_frame_words(input int k);
        return k;
    endfunction

endpackage

// File: rtl/mvm_feeder_if.sv
// Input element stream and result stream of the feeder, grouped for port connection.
// Both streams: a word transfers on a clock edge where valid && ready; the source holds
// valid, data and sideband (s_mat / m_last) stable until that transfer happens.
interface mvm_feeder_if #(parameter int B = 6);
    logic           s_valid;
    logic           s_ready;
    logic [B-1:0]   s_data;
    logic           s_mat;
    logic           m_valid;
    logic           m_ready;
    logic [2*B-1:0] m_data;
    logic           m_last;

    modport master (output s_valid, s_data, s_mat, m_ready,
                    input  s_ready, m_valid, m_data, m_last);
    modport slave  (input  s_valid, s_data, s_mat, m_ready,
                    output s_ready, m_valid, m_data, m_last);
endinterface

// File: rtl/mvm_frame_buf.sv
// Single-clock buffer RAM: one write port, one read port with a registered output.
module mvm_frame_buf #(
    parameter int W     = 6,
    parameter int DEPTH = 20,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/mvm_feeder.sv
// Buffers matrix/vector frames, replays them to the multiplier as one gap-free burst,
// then captures the K results and returns them on a back-pressured stream.
module mvm_feeder
    import mvm_pkg::*;
#(
    parameter int K       = 4,
    parameter int B       = 6,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           reset,
    mvm_feeder_if.slave    bus,
    output logic           loadMatrix,
    output logic           loadVector,
    output logic           start,
    input  logic           done,
    output logic [B-1:0]   data_in,
    input  logic [2*B-1:0] data_out,
    output logic           err_nomat,
    output logic           err_timeout,
    output state_t         dbg_state
);

    localparam int MAT_WORDS = mat_frame_words(K);
    localparam int VEC_WORDS = vec_frame_words(K);
    localparam int VEC_BASE  = K * K;
    localparam int CW        = $clog2(MAT_WORDS);
    localparam int RW        = (K > 1) ? $clog2(K) : 1;
    localparam int TW        = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] LAST_MATF = CW'(MAT_WORDS - 1);
    localparam logic [CW-1:0] LAST_VECF = CW'(VEC_WORDS - 1);
    localparam logic [CW-1:0] LAST_A    = CW'(K * K - 1);
    localparam logic [CW-1:0] LAST_X    = CW'(K - 1);
    localparam logic [RW-1:0] LAST_R    = RW'(K - 1);
    localparam logic [TW-1:0] TMAX      = TW'(TIMEOUT);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [RW-1:0] rcnt;
    logic [TW-1:0] tcnt;
    logic          mat_q;
    logic          mat_loaded;

    logic          s_fire, s_last, mat_eff, m_fire;
    logic [CW-1:0] in_waddr, in_raddr;
    logic          in_re, res_re;
    logic [RW-1:0] res_raddr;
    logic [B-1:0]  in_rdata;
    logic [2*B-1:0] res_rdata;

    // The frame type is only known from the first word, so that word uses s_mat directly.
    always_comb begin
        s_fire   = (state == ST_COLLECT) && bus.s_valid;
        mat_eff  = (cnt == '0) ? bus.s_mat : mat_q;
        s_last   = s_fire && (cnt == (mat_eff ? LAST_MATF : LAST_VECF));
        m_fire   = (state == ST_DRAIN) && bus.m_ready;
        in_waddr = mat_eff ? cnt : cnt + CW'(VEC_BASE);
    end

    // Read addresses run one element ahead so the registered RAM output lines up with SEND cycles.
    always_comb begin
        in_re     = 1'b0;
        in_raddr  = '0;
        res_re    = 1'b0;
        res_raddr = '0;
        case (state)
            ST_LDM:   in_re = 1'b1;
            ST_SENDM: if (cnt != LAST_A) begin
                in_re    = 1'b1;
                in_raddr = cnt + CW'(1);
            end
            ST_LDV: begin
                in_re    = 1'b1;
                in_raddr = CW'(VEC_BASE);
            end
            ST_SENDV: if (cnt != LAST_X) begin
                in_re    = 1'b1;
                in_raddr = CW'(VEC_BASE) + cnt + CW'(1);
            end
            ST_CAPT:  res_re = (rcnt == LAST_R);
            ST_DRAIN: begin
                res_re    = 1'b1;
                res_raddr = m_fire ? rcnt + RW'(1) : rcnt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_COLLECT;
            cnt        <= '0;
            rcnt       <= '0;
            tcnt       <= '0;
            mat_q      <= 1'b0;
            mat_loaded <= 1'b0;
        end else begin
            case (state)
                ST_COLLECT: if (s_fire) begin
                    if (cnt == '0) mat_q <= bus.s_mat;
                    if (s_last) begin
                        cnt <= '0;
                        if (mat_eff)         state <= ST_LDM;
                        else if (mat_loaded) state <= ST_LDV;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_LDM: state <= ST_SENDM;
                ST_SENDM: if (cnt == LAST_A) begin
                    cnt        <= '0;
                    mat_loaded <= 1'b1;
                    state      <= ST_LDV;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                ST_LDV: state <= ST_SENDV;
                ST_SENDV: if (cnt == LAST_X) begin
                    cnt   <= '0;
                    state <= ST_STRT;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                ST_STRT: begin
                    tcnt  <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: if (done) begin
                    tcnt  <= '0;
                    state <= ST_CAPT;
                end else if (tcnt == TMAX) begin
                    tcnt  <= '0;
                    state <= ST_COLLECT;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
                ST_CAPT: if (rcnt == LAST_R) begin
                    rcnt  <= '0;
                    state <= ST_DRAIN;
                end else begin
                    rcnt <= rcnt + RW'(1);
                end
                ST_DRAIN: if (m_fire) begin
                    if (rcnt == LAST_R) begin
                        rcnt  <= '0;
                        state <= ST_COLLECT;
                    end else begin
                        rcnt <= rcnt + RW'(1);
                    end
                end
                default: state <= ST_COLLECT;
            endcase
        end
    end

    mvm_frame_buf #(.W(B), .DEPTH(MAT_WORDS)) u_in_buf (
        .clk   (clk),
        .we    (s_fire),
        .waddr (in_waddr),
        .wdata (bus.s_data),
        .re    (in_re),
        .raddr (in_raddr),
        .rdata (in_rdata)
    );

    mvm_frame_buf #(.W(2*B), .DEPTH(K)) u_res_buf (
        .clk   (clk),
        .we    (state == ST_CAPT),
        .waddr (rcnt),
        .wdata (data_out),
        .re    (res_re),
        .raddr (res_raddr),
        .rdata (res_rdata)
    );

    // Outputs decode straight from state so an asynchronous reset drops them at once.
    assign bus.s_ready  = (state == ST_COLLECT);
    assign bus.m_valid  = (state == ST_DRAIN);
    assign bus.m_data   = (state == ST_DRAIN) ? res_rdata : '0;
    assign bus.m_last   = (state == ST_DRAIN) && (rcnt == LAST_R);
    assign loadMatrix   = (state == ST_LDM);
    assign loadVector   = (state == ST_LDV);
    assign start        = (state == ST_STRT);
    assign data_in      = (state == ST_SENDM || state == ST_SENDV) ? in_rdata : '0;
    assign err_nomat    = s_last && !mat_eff && !mat_loaded;
    assign err_timeout  = (state == ST_WAIT) && !done && (tcnt == TMAX);
    assign dbg_state    = state;

endmodule
